// File: rtl/keypad_minute_entry.sv
// Debounces keypad scanner codes and runs a '*'-digits-'#' entry FSM.
// On commit it issues a one-cycle load of the clamped minute value.
// Define ENTRY_TIMEOUT_EN to abandon an idle entry after TIMEOUT_CYCLES.
module keypad_minute_entry #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4000,
    parameter logic [6:0]  MAX_MINUTE      = 7'd99,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic       load,
    output logic [6:0] load_minute,
    output logic       entry_active,
    output logic [7:0] entry_bcd,
    output logic [1:0] digit_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'hF;

    logic [3:0]  cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  stable_q, stable_d;
    logic        armed_q, armed_d;
    logic        settled;
    logic        press;

    logic [1:0]  state_q, state_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [1:0]  count_q, count_d;
    logic [6:0]  minute_q, minute_d;
    logic [6:0]  raw_minute;

`ifdef ENTRY_TIMEOUT_EN
    logic [23:0] tmo_q, tmo_d;
    logic        expired;
    assign expired = (state_q == ST_ENTRY) && (tmo_q == TIMEOUT_CYCLES - 24'd1);
`endif

    assign settled = (cnt_q == DEBOUNCE_CYCLES - 16'd1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        armed_d  = armed_q;
        press    = 1'b0;
        if (key != cand_q) begin
            cand_d = key;
            cnt_d  = 16'd0;
        end else if (!settled) begin
            cnt_d = cnt_q + 16'd1;
        end
        // Only a transition of the stable code can fire or re-arm; 12-14 do neither.
        if (settled && (cand_q != stable_q)) begin
            stable_d = cand_q;
            if (cand_q == KEY_NONE) begin
                armed_d = 1'b1;
            end else if ((cand_q <= KEY_HASH) && armed_q) begin
                press   = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    assign raw_minute = 7'({3'b000, bcd_q[7:4]} * 7'd10) + {3'b000, bcd_q[3:0]};

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        count_d  = count_q;
        minute_d = minute_q;
        case (state_q)
            ST_IDLE: begin
                if (press && (cand_q == KEY_STAR)) begin
                    state_d = ST_ENTRY;
                    bcd_d   = 8'h00;
                    count_d = 2'd0;
                end
            end
            ST_ENTRY: begin
                if (press) begin
                    if (cand_q <= 4'd9) begin
                        bcd_d = {bcd_q[3:0], cand_q};
                        if (count_q != 2'd2) count_d = count_q + 2'd1;
                    end else if (cand_q == KEY_STAR) begin
                        bcd_d   = 8'h00;
                        count_d = 2'd0;
                    end else if (count_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_COMMIT;
                        minute_d = (raw_minute > MAX_MINUTE) ? MAX_MINUTE : raw_minute;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (expired) begin
                    state_d = ST_IDLE;
                    bcd_d   = 8'h00;
                    count_d = 2'd0;
                end
`endif
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

`ifdef ENTRY_TIMEOUT_EN
    always_comb begin
        tmo_d = 24'd0;
        if ((state_q == ST_ENTRY) && !press && !expired) tmo_d = tmo_q + 24'd1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q   <= KEY_NONE;
            cnt_q    <= 16'd0;
            stable_q <= KEY_NONE;
            armed_q  <= 1'b1;
            state_q  <= ST_IDLE;
            bcd_q    <= 8'h00;
            count_q  <= 2'd0;
            minute_q <= 7'd0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            count_q  <= count_d;
            minute_q <= minute_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= 24'd0;
        else     tmo_q <= tmo_d;
    end
`endif

    assign load         = (state_q == ST_COMMIT);
    assign load_minute  = minute_q;
    assign entry_active = (state_q == ST_ENTRY);
    assign entry_bcd    = bcd_q;
    assign digit_count  = count_q;

endmodule

// File: tb/tb_keypad_minute_entry.sv
// Self-checking bench: two instances (MAX_MINUTE 99 and 60) share one key stream,
// compared against a key-level behavioural model of the minute entry rules.
module tb_keypad_minute_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;

    logic       load_a, load_b;
    logic [6:0] load_minute_a, load_minute_b;
    logic       entry_active_a, entry_active_b;
    logic [7:0] entry_bcd_a, entry_bcd_b;
    logic [1:0] digit_count_a, digit_count_b;

    keypad_minute_entry #(
        .DEBOUNCE_CYCLES(16'd4), .MAX_MINUTE(7'd99), .TIMEOUT_CYCLES(24'd50)
    ) dut_a (
        .clk(clk), .rst(rst), .key(key), .load(load_a), .load_minute(load_minute_a),
        .entry_active(entry_active_a), .entry_bcd(entry_bcd_a), .digit_count(digit_count_a)
    );

    keypad_minute_entry #(
        .DEBOUNCE_CYCLES(16'd4), .MAX_MINUTE(7'd60), .TIMEOUT_CYCLES(24'd50)
    ) dut_b (
        .clk(clk), .rst(rst), .key(key), .load(load_b), .load_minute(load_minute_b),
        .entry_active(entry_active_b), .entry_bcd(entry_bcd_b), .digit_count(digit_count_b)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int         pulses_a = 0, pulses_b = 0;
    logic [6:0] cap_a = 7'd0, cap_b = 7'd0;

    always @(negedge clk) begin
        if (load_a) begin
            pulses_a++;
            cap_a = load_minute_a;
        end
        if (load_b) begin
            pulses_b++;
            cap_b = load_minute_b;
        end
    end

    // Reference model: entry mode plus the last two digits typed.
    bit m_entry = 1'b0;
    int m_tens = 0, m_ones = 0, m_count = 0;
    int m_last_a = 0, m_last_b = 0;

    function automatic int clamp(input int raw, input int mx);
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "/active_a"}, 32'(entry_active_a), 32'(m_entry));
        check({tag, "/active_b"}, 32'(entry_active_b), 32'(m_entry));
        check({tag, "/bcd_a"}, 32'(entry_bcd_a), 32'(m_tens * 16 + m_ones));
        check({tag, "/count_a"}, 32'(digit_count_a), 32'(m_count));
        check({tag, "/hold_a"}, 32'(load_minute_a), 32'(m_last_a));
        check({tag, "/hold_b"}, 32'(load_minute_b), 32'(m_last_b));
    endtask

    task automatic press(input int k, input int hold, input int gap);
        int pa, pb, exp_load;
        pa = pulses_a;
        pb = pulses_b;
        exp_load = 0;
        key = 4'(k);
        tick(hold);
        key = 4'hF;
        tick(gap);
        if (k <= 11) begin
            if (!m_entry) begin
                if (k == 10) begin
                    m_entry = 1'b1; m_tens = 0; m_ones = 0; m_count = 0;
                end
            end else if (k <= 9) begin
                m_tens = m_ones;
                m_ones = k;
                m_count = (m_count < 2) ? m_count + 1 : 2;
            end else if (k == 10) begin
                m_tens = 0; m_ones = 0; m_count = 0;
            end else begin
                if (m_count > 0) begin
                    exp_load = 1;
                    m_last_a = clamp(m_tens * 10 + m_ones, 99);
                    m_last_b = clamp(m_tens * 10 + m_ones, 60);
                end
                m_entry = 1'b0;
            end
        end
        check($sformatf("pulses_a key%0d", k), 32'(pulses_a - pa), 32'(exp_load));
        check($sformatf("pulses_b key%0d", k), 32'(pulses_b - pb), 32'(exp_load));
        if (exp_load != 0) begin
            check("minute_a", 32'(cap_a), 32'(m_last_a));
            check("minute_b", 32'(cap_b), 32'(m_last_b));
        end
        check_state($sformatf("key%0d", k));
    endtask

    task automatic model_reset();
        m_entry = 1'b0; m_tens = 0; m_ones = 0; m_count = 0;
        m_last_a = 0; m_last_b = 0;
    endtask

    initial begin
        int pa, pb, r, k;
        bit prev_quiet;

        rst = 1'b1;
        key = 4'hF;
        tick(3);
        check("rst/load_a", 32'(load_a), 32'd0);
        check("rst/load_b", 32'(load_b), 32'd0);
        check_state("rst");
        rst = 1'b0;
        tick(2);

        press(10, 10, 10);
        press(4, 10, 10);
        press(5, 10, 10);
        check("pre_commit_bcd", 32'(entry_bcd_a), 32'h45);
        press(11, 10, 10);

        press(10, 10, 10); press(7, 10, 10); press(11, 10, 10);
        press(10, 10, 10); press(1, 10, 10); press(2, 10, 10); press(3, 10, 10);
        check("three_digits_bcd", 32'(entry_bcd_a), 32'h23);
        press(11, 10, 10);

        // Bouncing '5': never stable long enough to register until the final hold.
        press(10, 10, 10);
        for (int i = 0; i < 6; i++) begin
            key = 4'd5; tick(2);
            key = 4'hF; tick(2);
        end
        check_state("bounce");
        press(5, 10, 10);
        check("bounce_count", 32'(digit_count_a), 32'd1);
        press(11, 10, 10);

        press(10, 10, 10); press(11, 10, 10);
        press(8, 10, 10);
        press(10, 10, 10); press(9, 10, 10); press(9, 10, 10); press(11, 10, 10);

        // Random key stream; never two event-less keys in a row so an
        // optional entry timeout cannot fire during this phase.
        prev_quiet = 1'b0;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 19));
            if (r >= 18)      k = 11;
            else if (r >= 16) k = 10;
            else              k = r;
            if (prev_quiet && (k >= 12)) k = int'($urandom_range(0, 9));
            prev_quiet = (k >= 12);
            press(k, int'($urandom_range(5, 8)), int'($urandom_range(5, 8)));
        end
        press(11, 6, 6);

        // Idle entry: abandoned only when the timeout feature is built in.
        pa = pulses_a;
        pb = pulses_b;
        press(10, 10, 10);
        press(2, 10, 10);
        tick(50);
`ifdef ENTRY_TIMEOUT_EN
        m_entry = 1'b0; m_tens = 0; m_ones = 0; m_count = 0;
`endif
        check_state("idle60");
        check("idle60/no_load_a", 32'(pulses_a - pa), 32'd0);
        check("idle60/no_load_b", 32'(pulses_b - pb), 32'd0);

        pa = pulses_a;
        press(10, 10, 10);
        press(3, 10, 10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(1);
        check_state("mid_reset");
        check("mid_reset/no_load", 32'(pulses_a - pa), 32'd0);
        press(10, 10, 10); press(6, 10, 10); press(11, 10, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
